// File: rtl/mux_2_arb_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
package mux_2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2.sv
// One-bit 2:1 multiplexer; one copy per data bit of the arbiter datapath.
module mux_2 (
  input  logic in_a,
  input  logic in_b,
  input  logic select,
  output logic out
);

  assign out = select ? in_b : in_a;

endmodule

// File: rtl/mux_2_arbiter.sv
// Round-robin burst arbiter between two requesters onto one ready/valid
// output. Only the grant state is registered; the datapath is purely combinational.
module mux_2_arbiter
  import mux_2_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  output logic             ready_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             ready_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             select
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  arb_state_e    state_q;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          last_grant_q;
  logic          cur_last;
  logic          beat;
  logic          burst_end;

  // Handshake outputs decode straight from the state register so that an
  // asynchronous reset drops them without waiting for a clock.
  always_comb begin
    ready_a   = 1'b0;
    ready_b   = 1'b0;
    out_valid = 1'b0;
    select    = SEL_A;
    unique case (state_q)
      GRANT_A: begin
        out_valid = req_a;
        ready_a   = out_ready;
      end
      GRANT_B: begin
        out_valid = req_b;
        ready_b   = out_ready;
        select    = SEL_B;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_last   = (select == SEL_B) ? last_b : last_a;
    beat       = out_valid && out_ready;
    burst_end  = beat && (cur_last || (beat_cnt_q == LAST_CNT));
    beat_cnt_d = beat_cnt_q;
    if (burst_end) begin
      beat_cnt_d = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      last_grant_q <= SEL_B;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (req_a && req_b) begin
            state_q <= (last_grant_q == SEL_B) ? GRANT_A : GRANT_B;
          end else if (req_a) begin
            state_q <= GRANT_A;
          end else if (req_b) begin
            state_q <= GRANT_B;
          end
        end
        GRANT_A: begin
          if (burst_end) begin
            last_grant_q <= SEL_A;
            state_q      <= req_b ? GRANT_B : IDLE;
          end
        end
        GRANT_B: begin
          if (burst_end) begin
            last_grant_q <= SEL_B;
            state_q      <= req_a ? GRANT_A : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2 u_mux (
      .in_a  (data_a[i]),
      .in_b  (data_b[i]),
      .select(select),
      .out   (out_data[i])
    );
  end

endmodule

// File: doc/mux_2_arbiter.md
MUX_2_ARBITER -- requirements
Module: mux_2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and the output.
REQ-002 Parameter MAX_BURST, default 4: maximum beats per grant; legal range 1..16.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_a  input  1  requester A has a valid beat on data_a.
REQ-006 Port data_a  input  WIDTH  requester A beat.
REQ-007 Port last_a  input  1  current A beat ends A's burst.
REQ-008 Port ready_a  output  1  A beat accepted when req_a && ready_a.
REQ-009 Ports req_b, data_b, last_b, ready_b: same as A, for requester B.
REQ-010 Port out_valid  output  1  out_data holds a valid beat.
REQ-011 Port out_data  output  WIDTH  beat of the granted requester.
REQ-012 Port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 Port select  output  1  current grant: 0 = A, 1 = B; also drives the mux select.

Function
REQ-014 FSM states: IDLE, GRANT_A, GRANT_B; state register only, no output registers on the data path.
REQ-015 IDLE: ready_a = ready_b = 0, out_valid = 0, select = 0.
REQ-016 IDLE, only req_a -> GRANT_A next cycle; only req_b -> GRANT_B; both -> the requester other than last_grant; neither -> stay.
REQ-017 GRANT_x: out_valid = req_x, ready_x = out_ready, ready of the other = 0, select = (state == GRANT_B).
REQ-018 out_data = data_b when select = 1, else data_a; combinational, zero-cycle latency from data_x to out_data.
REQ-019 Beat = req_x && out_ready in GRANT_x; each beat increments beat_cnt (width clog2(MAX_BURST)+1).
REQ-020 Burst ends on a beat with last_x = 1 or a beat with beat_cnt == MAX_BURST-1, whichever comes first.
REQ-021 At burst end: beat_cnt <= 0, last_grant <= x; next state GRANT_other if req_other is high that cycle, else IDLE.
REQ-022 A burst end goes directly to GRANT_other with no IDLE bubble, even when req_x is still high: strict round-robin alternation.
REQ-023 When req_x = 0 in GRANT_x, the grant holds (stall); beat_cnt and state are unchanged; no timeout.
REQ-024 When out_ready = 0 in GRANT_x, no beat occurs; state and beat_cnt are unchanged; out_valid follows req_x.
REQ-025 With MAX_BURST = 1, every beat ends the burst.
REQ-026 The other requester's req/last/data are ignored while it is not granted; no beat is ever lost or duplicated.

Reset
REQ-027 rst_n low clears immediately, without a clock: state = IDLE, beat_cnt = 0, last_grant = 1 (B), so A wins the first tie.
REQ-028 Outputs during reset: ready_a = ready_b = 0, out_valid = 0, select = 0, out_data = data_a.
REQ-029 Reset asserted mid-burst abandons the burst with no completion; the first grant after release follows REQ-016.

Structure
REQ-030 Shared package mux_2_arb_pkg holds the state enum typedef (IDLE, GRANT_A, GRANT_B) and the constants SEL_A = 0 and SEL_B = 1.
REQ-031 The data path is WIDTH instances of the existing 1-bit sub-module mux_2 (in_a = data_a[i], in_b = data_b[i], select = select, out = out_data[i]) in a generate loop; no other sub-modules.

Verification
REQ-032 Test: reset, then req_a = 1 with 3 beats (last_a on beat 3) and out_ready = 1. Required: GRANT_A one cycle after req, select = 0, 3 beats out, then IDLE.
REQ-033 Test: req_a = req_b = 1 after reset, both streaming with last never set. Required: A gets 4 beats, then B gets 4, then A gets 4; select toggles with no idle cycle between bursts.
REQ-034 Test: in GRANT_B, out_ready = 0 for 5 cycles mid-burst. Required: out_valid = 1, ready_b = 0, beat_cnt frozen, out_data = data_b held; the burst resumes and still totals 4 beats.
REQ-035 Test: in GRANT_A, req_a dropped for 3 cycles while req_b = 1. Required: the grant stays with A and ready_b = 0 throughout.
REQ-036 Test: rst_n pulsed low asynchronously between clock edges during beat 2 of a B burst. Required: ready_b and out_valid fall immediately, select = 0; after release with both requesting, A is granted first.
REQ-037 Test: MAX_BURST = 1 with data_a = 8'hA5 and data_b = 8'h5A, both requesting. Required: out_data alternates A5, 5A, A5, ... on consecutive accepted beats.
